// File: rtl/encode_mul_arb.sv
// encode_mul_arb: NUM_REQ requesters share one signed multiplier through a
// round-robin arbiter feeding a two-stage pipeline (S1 operands, S2 product).
// Optional build macro ENCODE_MUL_ARB_FIXED_PRIO_EN: fixed priority (lowest
// index wins); the round-robin pointer then stays at 0.
//
// Handshake: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; a result transfers on a rising edge where
// rsp_valid and rsp_ready are both high. rsp_valid/rsp_id/rsp_dout hold while
// rsp_valid=1 and rsp_ready=0, and req_ready never depends on itself.
module encode_mul_arb #(
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = 2,
   parameter int DIN0_WIDTH = 40,
   parameter int DIN1_WIDTH = 20,
   parameter int DOUT_WIDTH = 59
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             ce,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
   input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [ID_WIDTH-1:0]              rsp_id,
   output logic [DOUT_WIDTH-1:0]            rsp_dout
);

   // pipeline state
   logic                          s1_valid;
   logic [ID_WIDTH-1:0]           s1_id;
   logic signed [DIN0_WIDTH-1:0]  s1_din0;
   logic signed [DIN1_WIDTH-1:0]  s1_din1;
   logic                          s2_valid;
   logic [ID_WIDTH-1:0]           s2_id;
   logic [DOUT_WIDTH-1:0]         s2_dout;

   // arbitration state and decode
   logic [ID_WIDTH-1:0]           ptr;
   logic                          adv;
   logic                          grant_found;
   logic [ID_WIDTH-1:0]           grant_id;
   logic                          xfer;
   logic [ID_WIDTH-1:0]           next_ptr;

   // operands widened to the result width; the low DOUT_WIDTH bits of a
   // product only depend on the low DOUT_WIDTH bits of its operands
   logic signed [DOUT_WIDTH-1:0]  op_a;
   logic signed [DOUT_WIDTH-1:0]  op_b;
   logic signed [DOUT_WIDTH-1:0]  product;

   assign adv = ce & (~s2_valid | rsp_ready);

   // round-robin search starting at ptr, wrapping from NUM_REQ-1 to 0
   always_comb begin
      int idx;
      grant_found = 1'b0;
      grant_id    = '0;
      idx         = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_id    = ID_WIDTH'(idx);
         end
      end
   end

   assign xfer      = adv & grant_found & ~reset;
   assign req_ready = xfer ? (NUM_REQ'(1) << grant_id) : '0;
   assign next_ptr  = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

   assign op_a    = DOUT_WIDTH'(s1_din0);
   assign op_b    = DOUT_WIDTH'(s1_din1);
   assign product = op_a * op_b;

   // outputs come straight from S2; valid is masked while reset is held
   assign rsp_valid = s2_valid & ~reset;
   assign rsp_id    = s2_id;
   assign rsp_dout  = s2_dout;

   // pipeline advance, operand capture of the granted requester, pointer update
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_id    <= '0;
         s1_din0  <= '0;
         s1_din1  <= '0;
         s2_valid <= 1'b0;
         s2_id    <= '0;
         s2_dout  <= '0;
         ptr      <= '0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_id   <= s1_id;
            s2_dout <= product;
         end
         s1_valid <= xfer;
         // only the granted slice is captured, so other slices never leak in
         if (xfer) begin
            s1_id   <= grant_id;
            s1_din0 <= req_din0[int'(grant_id)*DIN0_WIDTH +: DIN0_WIDTH];
            s1_din1 <= req_din1[int'(grant_id)*DIN1_WIDTH +: DIN1_WIDTH];
`ifdef ENCODE_MUL_ARB_FIXED_PRIO_EN
            ptr     <= '0;
`else
            ptr     <= next_ptr;
`endif
         end
      end
   end

endmodule

// File: tb/tb_encode_mul_arb.sv
// Bench for encode_mul_arb (default parameters): vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_encode_mul_arb;

   localparam int N  = 4;
   localparam int W0 = 40;
   localparam int W1 = 20;
   localparam int WO = 59;

   logic               clk;
   logic               reset;
   logic               ce;
   logic [N-1:0]       req_valid;
   logic [N-1:0]       req_ready;
   logic [N*W0-1:0]    req_din0;
   logic [N*W1-1:0]    req_din1;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [1:0]         rsp_id;
   logic [WO-1:0]      rsp_dout;

   logic signed [W0-1:0] a [N];
   logic signed [W1-1:0] b [N];

   int n_checks = 0;
   int n_pass   = 0;

   encode_mul_arb dut (
      .clk       (clk),
      .reset     (reset),
      .ce        (ce),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_din0  (req_din0),
      .req_din1  (req_din1),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_dout  (rsp_dout)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // pack per-requester operands into the flattened buses
   always_comb begin
      for (int k = 0; k < N; k++) begin
         req_din0[k*W0 +: W0] = a[k];
         req_din1[k*W1 +: W1] = b[k];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [WO-1:0] ref_mul(input logic signed [W0-1:0] x,
                                             input logic signed [W1-1:0] y);
      longint p;
      p = longint'(x) * longint'(y);
      return p[WO-1:0];
   endfunction

   // reference model: accepted requests in order, each tagged with how many
   // pipeline steps it has taken (2 = visible at the output)
   typedef struct {
      int            id;
      logic [WO-1:0] dout;
      int            stage;
   } item_t;
   item_t exp_q[$];
   int    mptr = 0;

   // one clock: compare outputs against the model, take the edge, update model
   task automatic drive_cycle();
      bit         head2;
      bit         madv;
      bit         found;
      int         w;
      int         idx;
      logic [3:0] er;
      #1;
      head2 = (exp_q.size() > 0) && (exp_q[0].stage == 2);
      madv  = ce && (!head2 || rsp_ready);
      found = 0;
      w     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (mptr + k) % N;
         if (!found && req_valid[idx]) begin
            found = 1;
            w     = idx;
         end
      end
      er = (!reset && madv && found) ? 4'(1 << w) : 4'b0;
      check("req_ready", 64'(req_ready), 64'(er));
      check("rsp_valid", 64'(rsp_valid), 64'(!reset && head2));
      if (!reset && head2) begin
         check("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
         check("rsp_dout", 64'(rsp_dout), 64'(exp_q[0].dout));
      end
      @(posedge clk);
      if (reset) begin
         exp_q.delete();
         mptr = 0;
      end else if (madv) begin
         if (head2) void'(exp_q.pop_front());
         foreach (exp_q[i]) exp_q[i].stage = exp_q[i].stage + 1;
         if (found) begin
            exp_q.push_back('{id: w, dout: ref_mul(a[w], b[w]), stage: 1});
`ifndef ENCODE_MUL_ARB_FIXED_PRIO_EN
            mptr = (w + 1) % N;
`endif
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      req_valid = '0;
      repeat (n) drive_cycle();
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      drive_cycle();
      drive_cycle();
      reset = 1'b0;
   endtask

   typedef struct {
      logic signed [W0-1:0] din0;
      logic signed [W1-1:0] din1;
      logic [WO-1:0]        exp;
   } vec_t;
   vec_t vecs[8];

   initial begin
      int         ids[$];
      int         first_at;
      logic [1:0] held_id;
      logic [WO-1:0] held_dout;

      reset     = 1'b1;
      ce        = 1'b1;
      rsp_ready = 1'b1;
      req_valid = '0;
      for (int k = 0; k < N; k++) begin
         a[k] = '0;
         b[k] = '0;
      end

      vecs[0] = '{din0: -40'sd3, din1: 20'sd5, exp: -59'sd15};
      vecs[1] = '{din0: 40'sd7, din1: 20'sd6, exp: 59'd42};
      vecs[2] = '{din0: 40'h80_0000_0000, din1: 20'h80000, exp: (59'd1 << 58)};
      vecs[3] = '{din0: 40'h7F_FFFF_FFFF, din1: 20'h7FFFF,
                  exp: (59'd1 << 58) - (59'd1 << 39) - (59'd1 << 19) + 59'd1};
      vecs[4] = '{din0: -40'sd1, din1: -20'sd1, exp: 59'd1};
      vecs[5] = '{din0: 40'sd0, din1: 20'sd12345, exp: 59'd0};
      vecs[6] = '{din0: 40'h80_0000_0000, din1: 20'h7FFFF, exp: (59'd1 << 58) + (59'd1 << 39)};
      vecs[7] = '{din0: 40'sd123456789, din1: -20'sd1000, exp: -59'sd123456789000};

      // reset state
      do_reset();
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_rsp_id", 64'(rsp_id), 64'd0);
      check("reset_rsp_dout", 64'(rsp_dout), 64'd0);

      // single requests from the vector table: accept, then result two clocks on
      foreach (vecs[i]) begin
         a[0]      = vecs[i].din0;
         b[0]      = vecs[i].din1;
         req_valid = 4'b0001;
         drive_cycle();
         req_valid = '0;
         drive_cycle();
         check("vec_valid", 64'(rsp_valid), 64'd1);
         check("vec_id", 64'(rsp_id), 64'd0);
         check("vec_dout", 64'(rsp_dout), 64'(vecs[i].exp));
         drive_cycle();
      end

      // all requesters valid continuously: one grant per clock, no gaps
      do_reset();
      for (int k = 0; k < N; k++) begin
         a[k] = W0'(k + 1);
         b[k] = W1'(10 * (k + 1));
      end
      req_valid = 4'b1111;
      ids.delete();
      for (int c = 0; c < 8; c++) begin
         drive_cycle();
         if (rsp_valid) ids.push_back(int'(rsp_id));
      end
      check("rr_count", 64'(ids.size()), 64'd7);
      for (int k = 0; k < 6; k++) begin
`ifdef ENCODE_MUL_ARB_FIXED_PRIO_EN
         check("rr_seq", 64'(ids.size() > k ? ids[k] : -1), 64'd0);
`else
         check("rr_seq", 64'(ids.size() > k ? ids[k] : -1), 64'(k % N));
`endif
      end

      // backpressure with S1 and S2 both full
      do_reset();
      req_valid = 4'b0001;
      drive_cycle();
      req_valid = 4'b0010;
      drive_cycle();
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      held_id   = rsp_id;
      held_dout = rsp_dout;
      check("bp_held_valid", 64'(rsp_valid), 64'd1);
      repeat (3) begin
         drive_cycle();
         check("bp_ready_low", 64'(req_ready), 64'd0);
         check("bp_id_stable", 64'(rsp_id), 64'(held_id));
         check("bp_dout_stable", 64'(rsp_dout), 64'(held_dout));
      end
      rsp_ready = 1'b1;
      req_valid = '0;
      check("bp_drain_first", 64'(rsp_id), 64'd0);
      drive_cycle();
      check("bp_drain_second", 64'(rsp_id), 64'd1);
      idle(2);

      // ce low for two clocks mid-flight stretches latency by two
      do_reset();
      a[2]      = 40'sd9;
      b[2]      = -20'sd4;
      req_valid = 4'b0100;
      drive_cycle();
      req_valid = '0;
      ce        = 1'b0;
      first_at  = -1;
      for (int c = 1; c <= 10; c++) begin
         if (c == 3) ce = 1'b1;
         drive_cycle();
         if (rsp_valid && first_at < 0) first_at = c + 1;
      end
      check("ce_latency", 64'(first_at), 64'd4);

      // reset with both stages holding data
      do_reset();
      req_valid = 4'b1111;
      drive_cycle();
      drive_cycle();
      reset = 1'b1;
      drive_cycle();
      check("mid_reset_valid", 64'(rsp_valid), 64'd0);
      check("mid_reset_id", 64'(rsp_id), 64'd0);
      check("mid_reset_dout", 64'(rsp_dout), 64'd0);
      reset = 1'b0;
      #1;
      check("post_reset_grant", 64'(req_ready), 64'b0001);
      drive_cycle();
      idle(3);

      // randomized traffic
      do_reset();
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < N; k++) begin
            a[k] = {$urandom(), $urandom()};
            b[k] = W1'($urandom());
         end
         req_valid = 4'($urandom_range(0, 15));
         ce        = ($urandom_range(0, 9) != 0);
         rsp_ready = ($urandom_range(0, 3) != 0);
         reset     = ($urandom_range(0, 99) == 0);
         drive_cycle();
      end
      reset     = 1'b0;
      ce        = 1'b1;
      rsp_ready = 1'b1;
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
